// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state type and
// the sub-word store merge helper.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        LSU_IDLE   = 1'b0,
        LSU_RMW_WR = 1'b1
    } lsu_state_t;

    // Replace the addressed byte/halfword lane of old_word with store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] store_data,
        input logic [2:0]  width,
        input logic [1:0]  offset
    );
        logic [31:0] merged;
        merged = old_word;
        case (width)
            F3_B: begin
                case (offset)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    2'd3:    merged[31:24] = store_data[7:0];
                    default: merged        = old_word;
                endcase
            end
            F3_H: begin
                if (offset[1]) begin
                    merged[31:16] = store_data[15:0];
                end else begin
                    merged[15:0] = store_data[15:0];
                end
            end
            default: merged = store_data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load path lane select: picks the byte/halfword lane of a memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection
    always_comb begin
        byte_s = 8'h00;
        case (offset_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Width and extension
    always_comb begin
        data_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'h00_0000, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'h0000, half_s};
            F3_W:    data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a word-addressed data memory; sub-word stores
// use a stalling read-modify-write. Optional build macro: MISALIGN_TRAP_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [31:0]       rmw_data_q, rmw_data_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              misalign_q, misalign_d;

    logic              ld_f3_ok_s;
    logic              st_f3_ok_s;
    logic              ld_req_s;
    logic              st_req_s;
    logic              mis_s;
    logic              do_load_s;
    logic              do_sw_s;
    logic              do_sub_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [31:0]       align_data_s;
    logic [31:0]       merged_s;
    logic              unused_addr_s;

    // Bits above the memory window simply wrap.
    assign req_addr_s    = addr[ADDR_W+1:2];
    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Defined funct3 codes; stores only have the signed-width encodings
    always_comb begin
        ld_f3_ok_s = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ld_f3_ok_s = 1'b1;
            default:                        ld_f3_ok_s = 1'b0;
        endcase
    end

    assign st_f3_ok_s = ld_f3_ok_s & ~funct3[2];
    assign ld_req_s   = (state_q == LSU_IDLE) & req_valid & req_read & ~req_write & ld_f3_ok_s;
    assign st_req_s   = (state_q == LSU_IDLE) & req_valid & req_write & ~req_read & st_f3_ok_s;

`ifdef MISALIGN_TRAP_EN
    assign mis_s = (ld_req_s | st_req_s) &
                   (((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
`else
    assign mis_s = 1'b0;
`endif

    assign do_load_s = ld_req_s & ~mis_s;
    assign do_sw_s   = st_req_s & ~mis_s & (funct3 == F3_W);
    assign do_sub_s  = st_req_s & ~mis_s & (funct3 != F3_W);
    assign merged_s  = merge_store(mem_rdata, wdata, funct3, addr[1:0]);

    lsu_load_align u_load_align (
        .rdata_i  (mem_rdata),
        .funct3_i (funct3),
        .offset_i (addr[1:0]),
        .data_o   (align_data_s)
    );

    // Memory-side controls; forced quiet while reset is asserted
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = req_addr_s;
        mem_wdata = wdata;
        stall     = 1'b0;
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else if (state_q == LSU_RMW_WR) begin
            mem_write = 1'b1;
            mem_addr  = rmw_addr_q;
            mem_wdata = rmw_data_q;
        end else begin
            mem_read  = do_load_s | do_sub_s;
            mem_write = do_sw_s;
            stall     = do_sub_s;
        end
    end

    // Next-state and registered result logic
    always_comb begin
        state_d      = state_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_data_d   = rmw_data_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (do_sub_s) begin
                    state_d    = LSU_RMW_WR;
                    rmw_addr_d = req_addr_s;
                    rmw_data_d = merged_s;
                end else if (do_load_s) begin
                    load_valid_d = 1'b1;
                    load_data_d  = align_data_s;
                end else begin
                    misalign_d = mis_s;
                end
            end
            LSU_RMW_WR: state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            rmw_addr_q   <= '0;
            rmw_data_q   <= 32'h0000_0000;
            load_data_q  <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_data_q   <= rmw_data_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random
// traffic against a word-array reference model of memory.
module tb_load_store_unit;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_read, req_write;
    logic [2:0]        funct3;
    logic [31:0]       addr, wdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              stall;
    logic [31:0]       load_data;
    logic              load_valid, misalign;

    logic [31:0]       dmem [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_data;

    logic              exp_lv, exp_mis, chk_en;
    logic [31:0]       exp_ld;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .misalign(misalign)
    );

    assign mem_rdata = dmem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) dmem[bd_addr] <= bd_data;
        else if (mem_write) dmem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs are compared shortly after every rising edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("load_valid", 32'(load_valid), 32'(exp_lv));
            check("load_data", load_data, exp_ld);
            check("misalign", 32'(misalign), 32'(exp_mis));
        end
    end

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'b010 && (a % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = ref_mem[(a >> 2) % DEPTH];
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a >> 1) % 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] wd);
        logic [31:0] old, mask;
        int sh;
        old = ref_mem[(a >> 2) % DEPTH];
        if (f3 == 3'b000) begin
            sh   = 8 * int'(a % 4);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end
        sh   = 16 * int'((a >> 1) % 2);
        mask = 32'hFFFF << sh;
        return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    endfunction

    task automatic bd_write(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(idx);
        bd_data = val;
        ref_mem[idx] = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One request cycle (two for a sub-word store) with model update.
    task automatic op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        bit ld, st, mis, sub, sw;
        int wi;
        logic [31:0] mg;
        @(negedge clk);
        req_valid = v; req_read = rd; req_write = wr;
        funct3 = f3; addr = a; wdata = wd;
        ld  = v && rd && !wr && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        st  = v && wr && !rd && (f3 inside {3'b000, 3'b001, 3'b010});
        mis = (ld || st) && model_mis(f3, a);
        sw  = st && !mis && f3 == 3'b010;
        sub = st && !mis && f3 != 3'b010;
        wi  = int'((a >> 2) % DEPTH);
        #1;
        check("stall", 32'(stall), 32'(sub));
        check("mem_read", 32'(mem_read), 32'((ld && !mis) || sub));
        check("mem_write", 32'(mem_write), 32'(sw));
        if ((ld && !mis) || st && !mis) check("mem_addr", 32'(mem_addr), 32'(wi));
        if (sw) check("sw_wdata", mem_wdata, wd);
        exp_mis = mis;
        exp_lv  = ld && !mis;
        if (ld && !mis) exp_ld = model_load(f3, a);
        if (sw) ref_mem[wi] = wd;
        if (sub) begin
            mg = model_merge(f3, a, wd);
            @(negedge clk);
            #1;
            check("rmw_stall", 32'(stall), 32'h0);
            check("rmw_write", 32'(mem_write), 32'h1);
            check("rmw_read", 32'(mem_read), 32'h0);
            check("rmw_addr", 32'(mem_addr), 32'(wi));
            check("rmw_wdata", mem_wdata, mg);
            exp_lv  = 1'b0;
            exp_mis = 1'b0;
            ref_mem[wi] = mg;
        end
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
        exp_lv = 1'b0; exp_mis = 1'b0; exp_ld = 32'h0; chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) bd_write(i, $urandom);
        bd_write(2, 32'h80FF_7F19);
        bd_write(3, 32'h1111_1111);
        bd_write(5, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        op(1, 1, 0, 3'b000, 32'h08, 0); check("pin_lb08", exp_ld, 32'h0000_0019);
        op(1, 1, 0, 3'b000, 32'h0B, 0); check("pin_lb0b", exp_ld, 32'hFFFF_FF80);
        op(1, 1, 0, 3'b100, 32'h0A, 0); check("pin_lbu0a", exp_ld, 32'h0000_00FF);
        op(1, 1, 0, 3'b001, 32'h0A, 0); check("pin_lh0a", exp_ld, 32'hFFFF_80FF);
        op(1, 1, 0, 3'b101, 32'h0A, 0); check("pin_lhu0a", exp_ld, 32'h0000_80FF);
        op(1, 1, 0, 3'b010, 32'h08, 0); check("pin_lw08", exp_ld, 32'h80FF_7F19);
        idle();

        op(1, 0, 1, 3'b000, 32'h0D, 32'h0000_00AB);
        op(1, 1, 0, 3'b010, 32'h0C, 0); check("pin_sb_lw", exp_ld, 32'h1111_AB11);
        op(1, 0, 1, 3'b010, 32'h0C, 32'h0);
        op(1, 0, 1, 3'b001, 32'h0E, 32'h0000_CDEF);
        op(1, 1, 0, 3'b010, 32'h0C, 0); check("pin_sh_lw", exp_ld, 32'hCDEF_0000);
        op(1, 0, 1, 3'b010, 32'h10, 32'h1234_5678);
        idle();
        check("sw_word4", dmem[4], 32'h1234_5678);

        op(1, 1, 0, 3'b010, 32'h06, 0);
`ifdef MISALIGN_TRAP_EN
        check("pin_mis_flag", 32'(exp_mis), 32'h1);
`else
        check("pin_lw06", exp_ld, ref_mem[1]);
`endif
        op(1, 1, 0, 3'b010, 32'h1000_0008, 0); check("pin_wrap", exp_ld, 32'h80FF_7F19);
        op(1, 1, 0, 3'b011, 32'h08, 0);
        idle();

        // Reset lands in the write-back cycle of an SB to word 5.
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        funct3 = 3'b000; addr = 32'h14; wdata = 32'h0000_00AA;
        exp_lv = 1'b0; exp_mis = 1'b0;
        #1;
        check("rst_sb_stall", 32'(stall), 32'h1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_lv = 1'b0; exp_mis = 1'b0; exp_ld = 32'h0;
        #1;
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_word5", dmem[5], 32'h0);
        op(1, 1, 0, 3'b010, 32'h14, 0); check("pin_word5", exp_ld, 32'h0);

        for (int n = 0; n < 400; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 5));
            a = (n % 2 == 0) ? ($urandom & 32'hF000_003F) : ($urandom & 32'hF000_00FF);
            op(($urandom % 8) != 0, kind < 3, kind >= 3 && kind < 5,
               3'($urandom), a, $urandom);
        end
        idle();
        idle();
        for (int i = 0; i < DEPTH; i++) check("final_mem", dmem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
